// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared control-unit types and constants for interrupt sequencing
package cu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [7:0] VECTOR_BASE_DEFAULT   = 8'h40;
  localparam int         VECTOR_STRIDE_DEFAULT = 8;
  // Loaded into the vector when the request vanishes before the sample point.
  localparam logic [7:0] VECTOR_CANCELLED      = 8'h00;

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - lowest-index-wins priority encoder for interrupt requests
module irq_priority_encoder #(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] i_Request,
  output logic               o_Valid,
  output logic [IDX_W-1:0]   o_Index,
  output logic [NUM_IRQ-1:0] o_OneHot
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_Valid  = 1'b0;
    o_Index  = '0;
    o_OneHot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_Request[i]) begin
        o_Valid     = 1'b1;
        o_Index     = IDX_W'(i);
        o_OneHot    = '0;
        o_OneHot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - IME/halt/interrupt sequencer feeding the control-unit step counter
module irq_sequencer
  import cu_pkg::*;
#(
  parameter int         NUM_IRQ       = 5,
  parameter logic [7:0] VECTOR_BASE   = VECTOR_BASE_DEFAULT,
  parameter int         VECTOR_STRIDE = VECTOR_STRIDE_DEFAULT,
  parameter int         EI_DELAY      = 1
) (
  input  logic               i_Clk,
  input  logic               i_nRst,
  input  logic               i_Enable,
  input  logic [NUM_IRQ-1:0] i_Request,
  input  logic               i_Boundary,
  input  logic               i_EI,
  input  logic               i_DI,
  input  logic               i_RETI,
  input  logic               i_Halt,
  input  logic               i_Vector_Sample,
  input  logic               i_Service_Done,
  output logic               o_Service,
  output logic [7:0]         o_Vector,
  output logic [NUM_IRQ-1:0] o_Ack,
  output logic               o_IME,
  output logic               o_Halted
);

  localparam int         IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [1:0] EI_LOAD = 2'(EI_DELAY);

  irq_state_e         state_q, state_d;
  logic               ime_q, ime_d;
  logic [1:0]         ei_cnt_q, ei_cnt_d;
  logic [7:0]         vector_q, vector_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;

  logic               req_valid;
  logic [IDX_W-1:0]   req_index;
  logic [NUM_IRQ-1:0] req_onehot;
  logic [7:0]         win_vector;

  irq_priority_encoder #(
    .NUM_IRQ(NUM_IRQ),
    .IDX_W  (IDX_W)
  ) u_prio (
    .i_Request(i_Request),
    .o_Valid  (req_valid),
    .o_Index  (req_index),
    .o_OneHot (req_onehot)
  );

  // Modulo-256 arithmetic gives the required 8-bit truncation for free.
  assign win_vector = VECTOR_BASE + 8'(req_index) * 8'(VECTOR_STRIDE);

  always_comb begin
    state_d  = state_q;
    ime_d    = ime_q;
    ei_cnt_d = ei_cnt_q;
    vector_d = vector_q;
    ack_d    = '0;
    case (state_q)
      ST_RUN: begin
        if (i_Boundary && ime_q && req_valid) begin
          state_d  = ST_SERVICE;
          ime_d    = 1'b0;
          ei_cnt_d = 2'd0;
        end else begin
          if (i_Halt && !req_valid) begin
            state_d = ST_HALT;
          end
          if (i_DI) begin
            ime_d    = 1'b0;
            ei_cnt_d = 2'd0;
          end else if (i_RETI) begin
            ime_d    = 1'b1;
            ei_cnt_d = 2'd0;
          end else if (i_EI) begin
            ei_cnt_d = EI_LOAD;
          end else if (i_Boundary && (ei_cnt_q != 2'd0)) begin
            // The service check above already used the old IME at this boundary.
            ei_cnt_d = ei_cnt_q - 2'd1;
            if (ei_cnt_q == 2'd1) begin
              ime_d = 1'b1;
            end
          end
        end
      end
      ST_HALT: begin
        if (i_DI) begin
          ime_d    = 1'b0;
          ei_cnt_d = 2'd0;
        end
        if (req_valid) begin
          if (ime_q) begin
            state_d = ST_SERVICE;
            ime_d   = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_SERVICE: begin
        if (i_Vector_Sample) begin
          if (req_valid) begin
            vector_d = win_vector;
            ack_d    = req_onehot;
          end else begin
            vector_d = VECTOR_CANCELLED;
          end
        end
        if (i_Service_Done) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q  <= ST_RUN;
      ime_q    <= 1'b0;
      ei_cnt_q <= 2'd0;
      vector_q <= 8'h00;
      ack_q    <= '0;
    end else if (i_Enable) begin
      state_q  <= state_d;
      ime_q    <= ime_d;
      ei_cnt_q <= ei_cnt_d;
      vector_q <= vector_d;
      ack_q    <= ack_d;
    end
  end

  assign o_Service = (state_q == ST_SERVICE);
  assign o_Halted  = (state_q == ST_HALT);
  assign o_IME     = ime_q;
  assign o_Vector  = vector_q;
  assign o_Ack     = ack_q;

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Parametrised interrupt/halt sequencer for the CPU control unit. Generalises the fixed 5-line IME/halt/interrupt logic to NUM_IRQ channels with configurable vectors.
- Adds behaviour the current logic lacks: delayed EI, immediate RETI enable, and late vector sampling with interrupt cancellation.
- Sits between the interrupt-flag/enable registers and the control-unit step counter. It tells the interrupt microcode when to run and which vector to load into PC.

Parameters:
NUM_IRQ, 5, number of interrupt channels; index 0 has highest priority
VECTOR_BASE, 8'h40, vector of channel 0
VECTOR_STRIDE, 8, byte distance between consecutive channel vectors
EI_DELAY, 1, instruction boundaries between EI and IME becoming 1 (range 1..3)

Ports:
i_Clk  in  1  system clock
i_nRst  in  1  reset; asynchronous, active-low
i_Enable  in  1  clock enable; no state changes when 0
i_Request  in  NUM_IRQ  pending and enabled requests (IF & IE), level
i_Boundary  in  1  pulse on the opcode-fetch step (instruction boundary)
i_EI  in  1  pulse from EI microcode
i_DI  in  1  pulse from DI microcode
i_RETI  in  1  pulse from RETI microcode
i_Halt  in  1  pulse from HALT microcode
i_Vector_Sample  in  1  pulse from interrupt microcode when PC high/low is pushed and the vector is chosen
i_Service_Done  in  1  pulse on the last cycle of interrupt microcode
o_Service  out  1  run interrupt microcode instead of the next opcode
o_Vector  out  8  target PC low byte; high byte is 0x00
o_Ack  out  NUM_IRQ  one-cycle one-hot pulse that clears the serviced IF bit
o_IME  out  1  interrupt master enable
o_Halted  out  1  CPU halted; step counter must hold

Behaviour:
- All register updates require i_Enable=1. Reset value of every output and internal register is 0; the state is RUN.
- Priority: the lowest set index of i_Request wins. An internal vector is computed as VECTOR_BASE + idx*VECTOR_STRIDE, truncated to 8 bits.
- States:
  - RUN: executing opcodes.
  - HALT: o_Halted=1.
  - SERVICE: o_Service=1.
- RUN transitions:
  - i_Boundary & o_IME & |i_Request -> SERVICE. On the same edge IME<=0 and the EI counter is cleared.
  - i_Halt & ~|i_Request -> HALT.
  - i_Halt & |i_Request -> stay in RUN. No halt is entered and no halt bug is emulated.
- HALT transitions:
  - |i_Request & o_IME -> SERVICE, with IME<=0.
  - |i_Request & ~o_IME -> RUN (wake without service).
  - Otherwise stay in HALT. i_Boundary is ignored in HALT.
- SERVICE behaviour:
  - On i_Vector_Sample with |i_Request: o_Vector<=winning vector and o_Ack<=one-hot(idx) for exactly one cycle.
  - On i_Vector_Sample with ~|i_Request (request withdrawn): o_Vector<=8'h00, no o_Ack. This is the cancelled interrupt case.
  - i_Service_Done -> RUN. A sample and done in the same cycle are both honoured.
  - i_EI, i_DI, i_Halt and i_Boundary are ignored in SERVICE.
- o_Vector holds its value until the next sample or reset.
- IME rules in RUN (and HALT for DI):
  - i_DI: IME<=0 and EI counter<=0. DI beats EI and RETI when they arrive in the same cycle.
  - i_RETI: IME<=1 immediately and EI counter<=0.
  - i_EI: EI counter<=EI_DELAY. A second EI reloads the counter.
  - Counter decrement: each i_Boundary in RUN with counter>0 decrements it; the transition to 0 sets IME<=1 on that edge.
  - The interrupt check at that same boundary uses the old IME (0). With EI_DELAY=1, exactly one instruction after EI executes before any service.
  - EI while IME=1 has no visible effect.
- Latency: o_Service, o_Halted and o_IME change one cycle after the triggering pulse. o_Ack is asserted in the cycle after i_Vector_Sample.
- Reset mid-SERVICE: all outputs return to 0 asynchronously and the state returns to RUN. Pending requests are re-evaluated only after IME is re-enabled.

Decomposition:
- Shared package cu_pkg holds:
  - the state enum (RUN/HALT/SERVICE);
  - the default constants VECTOR_BASE_DEFAULT=8'h40 and VECTOR_STRIDE_DEFAULT=8;
  - the cancelled-vector constant 8'h00.
- One combinational sub-module, irq_priority_encoder (NUM_IRQ parameter), produces o_Valid, o_Index and o_OneHot. All sequencing stays in irq_sequencer.

Test Plan:
- Reset, then RETI; i_Request=5'b00100, i_Boundary -> o_Service=1 next cycle, o_IME=0. On sample: o_Vector=8'h50, o_Ack=5'b00100 for one cycle. After i_Service_Done: state RUN.
- EI, then boundary 1 with i_Request=5'b00001 -> no service, o_IME becomes 1. Boundary 2 -> service, vector 8'h40.
- EI and DI in the same cycle -> o_IME=0; two later boundaries with requests pending -> no service.
- HALT with IME=0 and no request -> o_Halted=1. Then i_Request=5'b10000 -> o_Halted=0, no o_Service, o_Vector unchanged.
- Service entered with i_Request=5'b00010; request drops to 0 before i_Vector_Sample -> o_Vector=8'h00, o_Ack=0.
- i_Request=5'b11000 and i_Enable=0 at the boundary -> no change. Then i_Enable=1 -> vector 8'h58 (channel 3 beats 4). Also assert i_nRst=0 mid-SERVICE -> all outputs 0 immediately.
